// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: latch enables, D/X bubble, F/D flush, forwarding selects and dump drain.
// Optional feature macro HAZ_FWD_EN: enables D-stage forwarding (otherwise RAW hazards stall until W).
module pipe_hazard_ctrl #(
    parameter int REG_W        = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D_valid,
    input  logic [REG_W-1:0] D_rs1,
    input  logic [REG_W-1:0] D_rs2,
    input  logic             D_rs1_used,
    input  logic             D_rs2_used,
    input  logic             D_rf_wr,
    input  logic [REG_W-1:0] D_rf_wr_addr,
    input  logic             D_is_load,
    input  logic             D_createdump,
    input  logic             X_pc_from_alu,
    input  logic             mem_stall,
    output logic             FD_en,
    output logic             DX_en,
    output logic             XM_en,
    output logic             MW_en,
    output logic             DX_bubble,
    output logic             FD_flush,
    output logic [1:0]       D_fwd1_sel,
    output logic [1:0]       D_fwd2_sel,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [DCW-1:0]   DRAIN_ONE  = DCW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef HAZ_FWD_EN
    localparam logic NO_FWD = 1'b0;
`else
    localparam logic NO_FWD = 1'b1;
`endif

    // Producer location codes; X and M coincide with the forwarding select encoding.
    localparam logic [1:0] LOC_NONE = 2'b00;
    localparam logic [1:0] LOC_X    = 2'b01;
    localparam logic [1:0] LOC_M    = 2'b10;
    localparam logic [1:0] LOC_W    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             rf_wr;
        logic [REG_W-1:0] addr;
    } sb_entry_t;

    state_t           state_r, state_s;
    logic [DCW-1:0]   drain_cnt_r, drain_cnt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    sb_entry_t        x_r, m_r, w_r;
    logic             x_is_load_r;
    logic [1:0]       loc1_s, loc2_s;
    logic             wait1_s, wait2_s, hazard_s, count_stall_s;

    function automatic logic hit(input sb_entry_t e, input logic used, input logic [REG_W-1:0] src);
        return e.valid & e.rf_wr & used & (e.addr == src);
    endfunction

    // Youngest in-flight writer of src wins.
    function automatic logic [1:0] locate(input logic used, input logic [REG_W-1:0] src,
                                          input sb_entry_t x, input sb_entry_t m, input sb_entry_t w);
        logic [1:0] loc;
        if (hit(x, used, src)) begin
            loc = LOC_X;
        end else if (hit(m, used, src)) begin
            loc = LOC_M;
        end else if (hit(w, used, src)) begin
            loc = LOC_W;
        end else begin
            loc = LOC_NONE;
        end
        return loc;
    endfunction

    assign loc1_s = D_valid ? locate(D_rs1_used, D_rs1, x_r, m_r, w_r) : LOC_NONE;
    assign loc2_s = D_valid ? locate(D_rs2_used, D_rs2, x_r, m_r, w_r) : LOC_NONE;

    // Without forwarding every X/M producer blocks; with it only a load sitting in X does.
    assign wait1_s  = ((loc1_s == LOC_X) & (x_is_load_r | NO_FWD)) | ((loc1_s == LOC_M) & NO_FWD);
    assign wait2_s  = ((loc2_s == LOC_X) & (x_is_load_r | NO_FWD)) | ((loc2_s == LOC_M) & NO_FWD);
    assign hazard_s = wait1_s | wait2_s;

    assign D_fwd1_sel = (NO_FWD || (loc1_s == LOC_W)) ? 2'b00 : loc1_s;
    assign D_fwd2_sel = (NO_FWD || (loc2_s == LOC_W)) ? 2'b00 : loc2_s;
    assign halt       = (state_r == ST_HALT);
    assign stall_cnt  = stall_cnt_r;

    // Latch enables, bubble/flush control and FSM next state.
    always_comb begin
        FD_en         = 1'b1;
        DX_en         = 1'b1;
        XM_en         = 1'b1;
        MW_en         = 1'b1;
        DX_bubble     = 1'b0;
        FD_flush      = 1'b0;
        state_s       = state_r;
        drain_cnt_s   = drain_cnt_r;
        count_stall_s = 1'b0;
        if (mem_stall || (state_r == ST_HALT)) begin
            FD_en = 1'b0;
            DX_en = 1'b0;
            XM_en = 1'b0;
            MW_en = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (X_pc_from_alu) begin
                        FD_flush  = 1'b1;
                        DX_bubble = 1'b1;
                    end else if (hazard_s) begin
                        FD_en         = 1'b0;
                        DX_bubble     = 1'b1;
                        count_stall_s = 1'b1;
                    end else if (D_valid && D_createdump) begin
                        state_s     = ST_DRAIN;
                        drain_cnt_s = '0;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    FD_en     = 1'b0;
                    DX_bubble = 1'b1;
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_s     = ST_HALT;
                        drain_cnt_s = '0;
                    end else begin
                        drain_cnt_s = drain_cnt_r + DRAIN_ONE;
                    end
                end
                default: begin
                    FD_en   = 1'b0;
                    DX_en   = 1'b0;
                    XM_en   = 1'b0;
                    MW_en   = 1'b0;
                    state_s = ST_RUN;
                end
            endcase
        end
    end

    // State, drain count, scoreboard shift and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= '0;
            stall_cnt_r <= '0;
            x_r         <= '0;
            m_r         <= '0;
            w_r         <= '0;
            x_is_load_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            drain_cnt_r <= drain_cnt_s;
            if (DX_en) begin
                if (DX_bubble) begin
                    x_r         <= '0;
                    x_is_load_r <= 1'b0;
                end else begin
                    x_r         <= '{valid: D_valid, rf_wr: D_rf_wr, addr: D_rf_wr_addr};
                    x_is_load_r <= D_valid & D_is_load;
                end
            end
            if (XM_en) begin
                m_r <= x_r;
            end
            if (MW_en) begin
                w_r <= m_r;
            end
            if (count_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
        end
    end

endmodule
